// File: rtl/maze_pkg.sv
// Shared constants, state and direction encodings for the maze round logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maze_pkg;

  localparam int COLS         = 18;
  localparam int ROWS         = 11;
  localparam int MAZE_BITS    = COLS * ROWS;
  localparam int TIME_LIMIT_S = 60;
  localparam int TICKS_PER_S  = 10;

  localparam logic [7:0] START_POS = 8'd19;
  localparam logic [7:0] GOAL_POS  = 8'd178;
  localparam logic [3:0] START_ROW = 4'd1;
  localparam logic [4:0] START_COL = 5'd1;
  localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);
  localparam logic [4:0] LAST_COL  = 5'(COLS - 1);
  localparam logic [9:0] MOVES_MAX = 10'd1023;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_CHECK   = 3'd2,
    S_PAUSE   = 3'd3,
    S_WIN     = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Linear cell index from row/col; COLS is constant so this is a fixed multiply.
  function automatic logic [7:0] cell_index(input logic [3:0] r, input logic [4:0] c);
    return ({4'd0, r} * 8'(COLS)) + {3'd0, c};
  endfunction

endpackage

// File: rtl/maze_round_timer.sv
// Round countdown: subsecond tick counter plus seconds remaining.
// Latency: load/decrement visible the cycle after load/en; expired is combinational.
// Backpressure: none; en is a single-cycle qualifier supplied by the sequencer.
module maze_round_timer
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  output logic [6:0] time_left,
  output logic       expired
);

  localparam logic [3:0] SUB_LAST  = 4'(TICKS_PER_S - 1);
  localparam logic [6:0] TIME_INIT = 7'(TIME_LIMIT_S);

  logic [3:0] sub_cnt;
  logic       sub_wrap;

  assign sub_wrap = (sub_cnt == SUB_LAST);
  // Expiry is flagged on the enabled tick that takes the last second to zero,
  // so the sequencer can prefer timeout over a move requested on that tick.
  assign expired  = en && sub_wrap && (time_left == 7'd1);

  // Subsecond count and seconds countdown; load restarts the round clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt   <= 4'd0;
      time_left <= TIME_INIT;
    end else if (load) begin
      sub_cnt   <= 4'd0;
      time_left <= TIME_INIT;
    end else if (en) begin
      if (sub_wrap) begin
        sub_cnt <= 4'd0;
        if (time_left != 7'd0) begin
          time_left <= time_left - 7'd1;
        end
      end else begin
        sub_cnt <= sub_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/maze_game_sequencer.sv
// Maze round sequencer: validates button moves against grid edge and wall map.
// Latency: button sampled on a tick cycle, pos updates 2 CLK later (end of CHECK).
// Backpressure: none; one move per tick, extra presses between ticks are ignored.
module maze_game_sequencer
  import maze_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 tick_10hz,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_ctrl,
  input  logic                 pause_sw,
  input  logic [MAZE_BITS-1:0] maze_map,
  output logic [7:0]           pos,
  output logic [2:0]           game_state,
  output logic [9:0]           moves,
  output logic [6:0]           time_left,
  output logic                 bump,
  output logic                 solved,
  output logic                 timed_out
);

  state_t     state, state_n;
  logic       ctrl_q;
  logic       ctrl_rise;
  logic [3:0] row, tgt_row, cand_row;
  logic [4:0] col, tgt_col, cand_col;
  logic       tgt_rej, cand_rej;
  logic [7:0] tgt_idx;
  logic       tgt_wall;
  logic       any_btn;
  dir_t       dir;
  logic       timer_load, timer_en, timer_expired;
  logic       latch_tgt, commit;

  assign ctrl_rise = btn_ctrl && !ctrl_q;
  assign any_btn   = btn_up || btn_down || btn_left || btn_right;
  assign tgt_idx   = cell_index(tgt_row, tgt_col);
  // An edge-rejected target never indexes the map, and the bound check keeps
  // the lookup inside the map even for an unexpected register value.
  assign tgt_wall  = !tgt_rej && (tgt_idx < 8'(MAZE_BITS)) && maze_map[tgt_idx];

  maze_round_timer u_timer (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (timer_load),
    .en        (timer_en),
    .time_left (time_left),
    .expired   (timer_expired)
  );

  // Resolve button priority and the edge rule into a candidate target cell.
  always_comb begin
    dir = DIR_RIGHT;
    if (btn_up)         dir = DIR_UP;
    else if (btn_down)  dir = DIR_DOWN;
    else if (btn_left)  dir = DIR_LEFT;
    cand_row = row;
    cand_col = col;
    cand_rej = 1'b0;
    case (dir)
      DIR_UP:    if (row == 4'd0)     cand_rej = 1'b1; else cand_row = row - 4'd1;
      DIR_DOWN:  if (row == LAST_ROW) cand_rej = 1'b1; else cand_row = row + 4'd1;
      DIR_LEFT:  if (col == 5'd0)     cand_rej = 1'b1; else cand_col = col - 5'd1;
      default:   if (col == LAST_COL) cand_rej = 1'b1; else cand_col = col + 5'd1;
    endcase
  end

  // Next-state and per-cycle controls; a ctrl edge overrides every state.
  always_comb begin
    state_n    = state;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    latch_tgt  = 1'b0;
    commit     = 1'b0;
    bump       = 1'b0;
    if (ctrl_rise) begin
      timer_load = 1'b1;
      state_n    = S_PLAY;
    end else begin
      case (state)
        S_PLAY: begin
          if (tick_10hz) begin
            if (pause_sw) begin
              state_n = S_PAUSE;
            end else begin
              timer_en = 1'b1;
              if (timer_expired) begin
                state_n = S_TIMEOUT;
              end else if (any_btn) begin
                latch_tgt = 1'b1;
                state_n   = S_CHECK;
              end
            end
          end
        end
        S_CHECK: begin
          state_n = S_PLAY;
          if (tgt_rej || tgt_wall) begin
            bump = 1'b1;
          end else begin
            commit = 1'b1;
            if (tgt_idx == GOAL_POS) state_n = S_WIN;
          end
        end
        S_PAUSE: begin
          // The resuming tick is consumed here and neither moves nor counts.
          if (tick_10hz && !pause_sw) state_n = S_PLAY;
        end
        default: begin
          state_n = state;
        end
      endcase
    end
  end

  // State, ctrl edge history, position, pending target and move count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      ctrl_q  <= 1'b0;
      row     <= START_ROW;
      col     <= START_COL;
      tgt_row <= START_ROW;
      tgt_col <= START_COL;
      tgt_rej <= 1'b0;
      moves   <= 10'd0;
    end else begin
      state  <= state_n;
      ctrl_q <= btn_ctrl;
      if (timer_load) begin
        row   <= START_ROW;
        col   <= START_COL;
        moves <= 10'd0;
      end else begin
        if (latch_tgt) begin
          tgt_row <= cand_row;
          tgt_col <= cand_col;
          tgt_rej <= cand_rej;
        end
        if (commit) begin
          row <= tgt_row;
          col <= tgt_col;
          if (moves != MOVES_MAX) moves <= moves + 10'd1;
        end
      end
    end
  end

  assign pos        = cell_index(row, col);
  assign game_state = state;
  assign solved     = (state == S_WIN);
  assign timed_out  = (state == S_TIMEOUT);

endmodule

// File: tb/tb_maze_game_sequencer.sv
module tb_maze_game_sequencer;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         tick_10hz, btn_up, btn_down, btn_left, btn_right, btn_ctrl, pause_sw;
  logic [197:0] maze_map;
  logic [7:0]   pos;
  logic [2:0]   game_state;
  logic [9:0]   moves;
  logic [6:0]   time_left;
  logic         bump, solved, timed_out;

  int tests = 0;
  int fails = 0;

  // Reference model: plain grid coordinates, seconds and tick counts.
  int m_state, m_row, m_col, m_moves, m_time, m_sub;

  maze_game_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .tick_10hz(tick_10hz),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_ctrl(btn_ctrl), .pause_sw(pause_sw), .maze_map(maze_map),
    .pos(pos), .game_state(game_state), .moves(moves), .time_left(time_left),
    .bump(bump), .solved(solved), .timed_out(timed_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_row = 1; m_col = 1; m_moves = 0; m_time = 60; m_sub = 0;
  endtask

  task automatic model_restart();
    m_state = 1; m_row = 1; m_col = 1; m_moves = 0; m_time = 60; m_sub = 0;
  endtask

  // One tick of the round rules; reports whether a move is evaluated and rejected.
  task automatic model_tick(input bit u, input bit d, input bit l, input bit r, input bit p,
                            output bit exp_check, output bit exp_bump);
    int dr, dc, nr, nc;
    exp_check = 0;
    exp_bump  = 0;
    if (m_state == 1) begin
      if (p) begin
        m_state = 3;
      end else begin
        m_sub++;
        if (m_sub == 10) begin
          m_sub = 0;
          m_time--;
        end
        if (m_time == 0) begin
          m_state = 5;
        end else if (u || d || l || r) begin
          dr = 0; dc = 0;
          if (u) dr = -1;
          else if (d) dr = 1;
          else if (l) dc = -1;
          else dc = 1;
          nr = m_row + dr;
          nc = m_col + dc;
          exp_check = 1;
          if (nr < 0 || nr >= 11 || nc < 0 || nc >= 18 || maze_map[nr*18 + nc]) begin
            exp_bump = 1;
          end else begin
            m_row = nr;
            m_col = nc;
            if (m_moves < 1023) m_moves++;
            if (nr*18 + nc == 178) m_state = 4;
          end
        end
      end
    end else if (m_state == 3 && !p) begin
      m_state = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pos"},       pos,        m_row*18 + m_col);
    check({tag, ".moves"},     moves,      m_moves);
    check({tag, ".time"},      time_left,  m_time);
    check({tag, ".state"},     game_state, m_state);
    check({tag, ".solved"},    solved,     m_state == 4);
    check({tag, ".timed_out"}, timed_out,  m_state == 5);
  endtask

  // Apply one tick with the given buttons, then check CHECK visibility, bump and outputs.
  task automatic step(input string tag, input bit u, input bit d, input bit l, input bit r, input bit p);
    bit ec, eb;
    model_tick(u, d, l, r, p, ec, eb);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; pause_sw = p;
    tick_10hz = 1'b1;
    @(negedge CLK);
    tick_10hz = 1'b0;
    check({tag, ".state1"}, game_state, ec ? 2 : m_state);
    check({tag, ".bump1"},  bump,       eb);
    @(negedge CLK);
    check({tag, ".bump2"},  bump,       0);
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    @(negedge CLK);
    check_outputs(tag);
  endtask

  task automatic ctrl_edge(input string tag);
    btn_ctrl = 1'b1;
    @(negedge CLK);
    btn_ctrl = 1'b0;
    model_restart();
    check_outputs(tag);
    check({tag, ".bump"}, bump, 0);
    @(negedge CLK);
  endtask

  initial begin
    int guard;
    logic [6:0] t_before;
    RST_N = 1'b0;
    tick_10hz = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_ctrl = 0; pause_sw = 0;
    for (int i = 0; i < 198; i++) maze_map[i] = ($urandom_range(0, 3) == 0);
    maze_map[1] = 1'b1;
    maze_map[2] = 1'b0; maze_map[18] = 1'b0; maze_map[19] = 1'b0; maze_map[20] = 1'b0;
    maze_map[178] = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_outputs("reset");
    check("reset.bump", bump, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // IDLE ignores ticks, buttons and pause.
    step("idle_btn", 1, 0, 0, 1, 0);
    step("idle_pause", 0, 0, 0, 0, 1);
    pause_sw = 0;

    ctrl_edge("start");
    step("right_open", 0, 0, 0, 1, 0);
    step("up_left_prio", 1, 0, 1, 0, 0);
    step("up_row0_edge", 1, 0, 0, 0, 0);
    step("down_back", 0, 1, 0, 0, 0);
    step("left_back", 0, 0, 1, 0, 0);
    step("up_wall", 1, 0, 0, 0, 0);
    step("left_col0", 0, 0, 1, 0, 0);
    step("left_edge", 0, 0, 1, 0, 0);

    // Random walk on the random map with occasional pauses.
    for (int i = 0; i < 150; i++) begin
      step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 9) == 0);
    end
    pause_sw = 0;

    // Timeout round: goal walled in so only the timer can end it.
    maze_map[160] = 1'b1; maze_map[177] = 1'b1; maze_map[179] = 1'b1; maze_map[196] = 1'b1;
    ctrl_edge("restart_to");
    guard = 0;
    while (m_state != 5 && guard < 800) begin
      if (guard == 200) begin
        t_before = time_left;
        for (int k = 0; k < 50; k++) step("paused", 0, 0, 0, 0, 1);
        check("pause_time_hold", time_left, t_before);
        step("resume", 1, 0, 0, 0, 0);
        check("resume_time_hold", time_left, t_before);
      end else if (m_time == 1 && m_sub == 9) begin
        step("tie_tick", 0, 0, 0, 1, 0);
      end else begin
        step("to_rand", $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 0);
      end
      guard++;
    end
    check("timeout_reached", timed_out, 1);
    check("timeout_time0", time_left, 0);
    step("to_hold", 0, 1, 0, 0, 0);
    step("to_hold2", 0, 0, 0, 0, 1);
    pause_sw = 0;

    // Win round on an open map: 8 downs then 15 rights reach the goal.
    for (int i = 0; i < 198; i++) maze_map[i] = 1'b0;
    ctrl_edge("restart_win");
    for (int i = 0; i < 8; i++) step("win_down", 0, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) step("win_right", 0, 0, 0, 1, 0);
    check("win_state", game_state, 4);
    check("win_moves", moves, 23);
    step("win_hold", 0, 0, 1, 0, 0);
    ctrl_edge("restart_from_win");

    // Asynchronous reset while the move is in CHECK.
    btn_right = 1'b1; tick_10hz = 1'b1;
    @(posedge CLK);
    #1;
    tick_10hz = 1'b0; btn_right = 1'b0;
    check("pre_rst_check", game_state, 2);
    RST_N = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.bump", bump, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_outputs("post_rst");
    ctrl_edge("after_rst");
    step("after_rst_move", 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
